// File: rtl/alu_seq.sv
// Registered 8-op ALU with valid/ready handshakes on both sides and an
// iterative one-bit-per-cycle logical left shifter.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic             zeroFlag,
  output logic             overflowFlag,
  output logic             carryoutFlag,
  output logic             negativeFlag,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_r, state_n;

  logic [WIDTH-1:0] work_r;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] data_r;
  logic             zf_r, vf_r, cf_r, nf_r;
  logic             out_valid_r, busy_r;

  logic             accept_s, shift_start_s;
  logic [SHW-1:0]   amount_s;
  logic [WIDTH:0]   sum_s, dif_s;
  logic [WIDTH-1:0] res_s, shl_s;
  logic             c_s, v_s, z_s, n_s, slt_s;

  assign in_ready      = (state_r == IDLE) | ((state_r == HOLD) & out_ready);
  assign accept_s      = in_valid & in_ready;
  assign amount_s      = busB[SHW-1:0];
  assign shift_start_s = (control == OP_SHL) & (amount_s != {SHW{1'b0}});

  assign sum_s = {1'b0, busA} + {1'b0, busB};
  assign dif_s = {1'b0, busA} + {1'b0, ~busB} + {{WIDTH{1'b0}}, 1'b1};
  assign slt_s = ($signed(busA) < $signed(busB));
  assign shl_s = {work_r[MSB-1:0], 1'b0};

  // Single-cycle result and carry/overflow for the opcode on the input bus
  always_comb begin
    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (control)
      OP_ADD: begin
        res_s = sum_s[MSB:0];
        c_s   = sum_s[WIDTH];
        v_s   = (busA[MSB] == busB[MSB]) & (sum_s[MSB] != busA[MSB]);
      end
      OP_SUB: begin
        res_s = dif_s[MSB:0];
        c_s   = dif_s[WIDTH];
        v_s   = (busA[MSB] != busB[MSB]) & (dif_s[MSB] != busA[MSB]);
      end
      OP_AND:  res_s = busA & busB;
      OP_OR:   res_s = busA | busB;
      OP_XOR:  res_s = busA ^ busB;
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, slt_s};
      // Zero-amount shift takes the single-cycle path
      OP_SHL:  res_s = busA;
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // NOP reports zero with Z forced low
  assign z_s = (control != OP_NOP) & (res_s == {WIDTH{1'b0}});
  assign n_s = res_s[MSB];

  // Next-state decode
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE, HOLD: begin
        if (accept_s) begin
          state_n = shift_start_s ? SHIFT : HOLD;
        end else if ((state_r == HOLD) & ~out_ready) begin
          state_n = HOLD;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          state_n = HOLD;
        end else begin
          state_n = SHIFT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, shifter and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      work_r      <= {WIDTH{1'b0}};
      cnt_r       <= {SHW{1'b0}};
      data_r      <= {WIDTH{1'b0}};
      zf_r        <= 1'b0;
      vf_r        <= 1'b0;
      cf_r        <= 1'b0;
      nf_r        <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      out_valid_r <= (state_n == HOLD);
      busy_r      <= (state_n == SHIFT);
      if (accept_s) begin
        if (shift_start_s) begin
          work_r <= busA;
          cnt_r  <= amount_s;
        end else begin
          data_r <= res_s;
          zf_r   <= z_s;
          vf_r   <= v_s;
          cf_r   <= c_s;
          nf_r   <= n_s;
        end
      end else if (state_r == SHIFT) begin
        work_r <= shl_s;
        cnt_r  <= cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          data_r <= shl_s;
          zf_r   <= (shl_s == {WIDTH{1'b0}});
          vf_r   <= 1'b0;
          cf_r   <= work_r[MSB];
          nf_r   <= shl_s[MSB];
        end
      end
    end
  end

  assign out_valid    = out_valid_r;
  assign busy         = busy_r;
  assign dataOut      = data_r;
  assign zeroFlag     = zf_r;
  assign overflowFlag = vf_r;
  assign carryoutFlag = cf_r;
  assign negativeFlag = nf_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: 32-bit instance for handshake,
// arithmetic and shift latency, plus an 8-bit instance for width scaling.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] busA, busB, dataOut;
  logic [2:0]  control;
  logic        zeroFlag, overflowFlag, carryoutFlag, negativeFlag;

  logic       iv8, ir8, ov8, or8, busy8;
  logic [7:0] a8, b8, d8;
  logic [2:0] ctl8;
  logic       z8, v8, c8, n8;

  alu_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .busA(busA), .busB(busB), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .dataOut(dataOut), .zeroFlag(zeroFlag),
    .overflowFlag(overflowFlag), .carryoutFlag(carryoutFlag),
    .negativeFlag(negativeFlag), .busy(busy)
  );

  alu_seq #(.WIDTH(8), .SHW(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .busA(a8), .busB(b8), .control(ctl8), .out_valid(ov8),
    .out_ready(or8), .dataOut(d8), .zeroFlag(z8),
    .overflowFlag(v8), .carryoutFlag(c8),
    .negativeFlag(n8), .busy(busy8)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  f;   // {Z, V, C, N}
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic        c, v;
    logic [31:0] d;
    c = 1'b0;
    v = 1'b0;
    d = 32'd0;
    case (op)
      3'd1: begin
        s = {1'b0, a} + {1'b0, b};
        d = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (d[31] != a[31]);
      end
      3'd2: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        d = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (d[31] != a[31]);
      end
      3'd3: d = a & b;
      3'd4: d = a | b;
      3'd5: d = a ^ b;
      3'd6: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd7: begin
        d = a;
        for (int i = 0; i < int'(b[4:0]); i++) begin
          c = d[31];
          d = d << 1;
        end
      end
      default: d = 32'd0;
    endcase
    e.d = d;
    e.f = (op == 3'd0) ? 4'b0000 : {(d == 32'd0), v, c, d[31]};
    return e;
  endfunction

  // Consumer side: every handshake completed on the next edge pops one entry
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", dataOut, e.d);
        chk("flags", {28'd0, zeroFlag, overflowFlag, carryoutFlag, negativeFlag}, {28'd0, e.f});
      end
      pops++;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    in_valid = 1'b1;
    control  = op;
    busA     = a;
    busB     = b;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("accept_wait", 32'(n < 100), 32'd1);
    sbq.push_back(model(op, a, b));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain", 32'(n < 100), 32'd1);
  endtask

  task automatic shift_lat(input logic [31:0] a, input logic [31:0] b, input int want_lat, input string tag);
    int lat;
    int bad;
    issue(3'd7, a, b);
    lat = 1;
    bad = 0;
    while (!out_valid && lat < 200) begin
      if (!busy || in_ready) bad++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, want_lat);
    chk({tag, "_busy_noready"}, bad, 0);
    drain();
  endtask

  initial begin
    int c0, p0, seen, lat;
    rst_n = 1'b0;
    in_valid = 1'b0; control = 3'd0; busA = 32'd0; busB = 32'd0; out_ready = 1'b1;
    iv8 = 1'b0; ctl8 = 3'd0; a8 = 8'd0; b8 = 8'd0; or8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dataOut", dataOut, 32'd0);
    chk("rst_flags", {28'd0, zeroFlag, overflowFlag, carryoutFlag, negativeFlag}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    issue(3'd1, 32'h7FFF_FFFF, 32'd1);
    chk("add_latency1", {31'd0, out_valid}, 32'd1);
    drain();
    issue(3'd2, 32'd5, 32'd5);
    drain();
    issue(3'd2, 32'd3, 32'd5);
    drain();

    shift_lat(32'h8000_0001, 32'd31, 32, "shl31");
    shift_lat(32'h8000_0001, 32'd1, 2, "shl1");
    shift_lat(32'h0000_00A5, 32'd0, 1, "shl0");

    c0 = cyc;
    p0 = pops;
    issue(3'd3, 32'hFFFF_FFFF, 32'd1);
    issue(3'd4, 32'hFFFF_FFFF, 32'd1);
    issue(3'd5, 32'hFFFF_FFFF, 32'd1);
    issue(3'd6, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("b2b_results", pops - p0, 4);
    chk("b2b_cycles", cyc - c0, 5);

    out_ready = 1'b0;
    issue(3'd1, 32'd3, 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk("hold_data", dataOut, 32'd7);
      chk("hold_flags", {28'd0, zeroFlag, overflowFlag, carryoutFlag, negativeFlag}, 32'd0);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    drain();

    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    drain();

    issue(3'd7, 32'd1, 32'd20);
    repeat (9) step();
    chk("mid_shift_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    sbq.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (25) begin
      if (out_valid || busy) seen++;
      step();
    end
    chk("abort_no_stale", seen, 0);

    iv8 = 1'b1; ctl8 = 3'd1; a8 = 8'hFF; b8 = 8'h01;
    chk("w8_in_ready", {31'd0, ir8}, 32'd1);
    step();
    iv8 = 1'b0;
    chk("w8_add_valid", {31'd0, ov8}, 32'd1);
    chk("w8_add_data", {24'd0, d8}, 32'd0);
    chk("w8_add_flags", {28'd0, z8, v8, c8, n8}, 32'b1010);
    step();
    iv8 = 1'b1; ctl8 = 3'd7; a8 = 8'h01; b8 = 8'h07;
    step();
    iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 50) begin
      if (!busy8) lat = lat + 100;
      step();
      lat++;
    end
    chk("w8_shl_latency", lat, 8);
    chk("w8_shl_data", {24'd0, d8}, 32'h80);
    chk("w8_shl_flags", {28'd0, z8, v8, c8, n8}, 32'b0001);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 32-bit combinational 8-op ALU.
- Adds a valid/ready handshake on both input and output, and registered result and flags.
- Replaces the 2-bit shifter with an iterative logical left shift of up to WIDTH-1 places, one bit per cycle.
- Sits between the register-file read stage and writeback in the lab datapath; single-cycle ops sustain one result per clock.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, power of 2).
- SHW, 5, shift-amount field width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request this cycle
- busA  input  WIDTH  operand A
- busB  input  WIDTH  operand B; busB[SHW-1:0] is the shift amount for op 7
- control  input  3  opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT (signed A<B), 7 SHL
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- dataOut  output  WIDTH  registered result
- zeroFlag, overflowFlag, carryoutFlag, negativeFlag  output  1 each  registered flags
- busy  output  1  iterative shift in progress

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset (rst_n=0, immediate):
  - state=IDLE.
  - in_ready=1 at the first edge after release; combinationally it is 1 while in IDLE.
  - out_valid=0, dataOut=0, all flags=0, busy=0.
  - Reset mid-shift or mid-hold abandons the operation; no output is produced.
- States:
  - IDLE: no pending result.
  - SHIFT: iterating.
  - HOLD: out_valid=1, waiting for out_ready.
- in_ready = (state==IDLE) | (state==HOLD & out_ready).
- Accept: in_valid & in_ready on a rising edge.
  - Operands and opcode are latched internally; inputs may change afterwards.
- Ops 0-6 (single-cycle):
  - Result and flags are written on the accept edge; next state is HOLD.
  - Latency is 1 cycle: out_valid is high the cycle after accept.
- Op 7 with amount N = busB[SHW-1:0]:
  - N=0: behaves as a single-cycle op; result=A, C=0.
  - N>0: next state is SHIFT with counter=N and busy=1.
  - Each SHIFT cycle: work reg <<= 1, C ← bit shifted out, counter−1.
  - When counter reaches 0, result and flags are written and next state is HOLD.
  - Latency is N+1 cycles from accept to out_valid.
  - in_ready=0 throughout SHIFT.
- HOLD:
  - dataOut and flags are stable while out_valid=1 and out_ready=0.
  - out_ready=1 with no new accept: next state IDLE, out_valid=0.
  - out_ready=1 with a simultaneous accept: pop and push on the same edge; back-to-back single-cycle ops give 1 result/clock.
- Arithmetic (modulo 2^WIDTH):
  - ADD: result=A+B; C=carry out of MSB; V=(A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - SUB: result=A+~B+1; C=carry out (1 = no borrow, i.e. A≥B unsigned); V=(A[msb]!=B[msb]) & (R[msb]!=A[msb]).
  - SLT: result=1 if signed A<B, else 0; C=V=0.
  - AND/OR/XOR: bitwise; C=V=0.
  - SHL: V=0; C=last bit shifted out.
  - Z=(result==0) and N=result[WIDTH-1] for all ops except NOP.
  - NOP: result=0 and all four flags=0 (Z forced 0).
- Opcode and operands are sampled only at accept. in_valid while in_ready=0 is ignored; the producer must hold its request until accepted.

Test Plan:
- Reset then ADD A=0x7FFFFFFF, B=1; out_ready=1 → next cycle out_valid=1, dataOut=0x80000000, V=1, N=1, C=0, Z=0.
- SUB A=5, B=5 → dataOut=0, Z=1, C=1, V=0. Then SUB A=3, B=5 → 0xFFFFFFFE, C=0, N=1.
- SHL A=0x80000001, B=31 → busy for 31 cycles, in_ready=0; out_valid at cycle 32 after accept; dataOut=0x80000000, C=0. Repeat with B=1 → dataOut=0x00000002, C=1, latency 2.
- Back-to-back AND, OR, XOR, SLT (A=0xFFFFFFFF, B=1) with out_ready=1 → 4 results on 4 consecutive cycles; SLT gives 1. Then hold out_ready=0 for 3 cycles → dataOut and flags frozen, in_ready=0.
- NOP → dataOut=0, all flags 0. Assert rst_n=0 at SHIFT cycle 10 of a 20-bit shift → out_valid=0 and busy=0 immediately; IDLE after release, no stale result emitted.
- WIDTH=8, SHW=3: ADD 0xFF+0x01 → 0x00, C=1, Z=1. SHL 0x01 by 7 → 0x80, N=1.
